sdf_bfu_stage: RTL

Radix-2 single-path delay-feedback (R2SDF) DIF butterfly stage with a gated feedback delay line of DELAY_STAGES complex words. One frame of 2·DELAY_STAGES complex samples enters the stage. The stage emits the butterfly sums x[n]+x[n+D] and then the differences x[n]−x[n+D] in natural half order. It sits between the previous FFT stage (or the input framer) and the twiddle-multiply stage.

---
 rtl/fft_pkg.sv | 31 +++
 rtl/fb_delay_line.sv | 31 +++
 rtl/sdf_bfu_stage.sv | 129 ++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared FFT definitions: butterfly FSM encoding, complex-word helpers and
// a width-generic saturating clamp used by the butterfly datapaths.
package fft_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        BFLY  = 2'd1,
        DRAIN = 2'd2
    } bfu_state_t;

    // Half-word width of a packed complex word ({re, im}).
    function automatic int half_w(input int bit_width);
        return bit_width / 2;
    endfunction

    // Clamp v into the signed range of a w-bit two's complement number.
    function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            sat_clamp = hi;
        end else if (v < lo) begin
            sat_clamp = lo;
        end else begin
            sat_clamp = v;
        end
    endfunction

endpackage

// File: rtl/fb_delay_line.sv
// Enabled shift register holding the R2SDF feedback words; the oldest word
// is presented on dout. Asynchronous clear empties every stage.
module fb_delay_line #(
    parameter int BIT_WIDTH = 32,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 en,
    input  logic [BIT_WIDTH-1:0] din,
    output logic [BIT_WIDTH-1:0] dout
);

    logic [BIT_WIDTH-1:0] taps [DEPTH];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                taps[i] <= '0;
            end
        end else if (en) begin
            taps[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign dout = taps[DEPTH-1];

endmodule

// File: rtl/sdf_bfu_stage.sv
// Radix-2 SDF DIF butterfly stage: emits x[n]+x[n+D] during the second half
// of a frame and replays the stored differences during the next first half.
module sdf_bfu_stage
    import fft_pkg::*;
#(
    parameter int BIT_WIDTH    = 32,
    parameter int DELAY_STAGES = 4,
    parameter int SCALE        = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic                 in_sof,
    input  logic [BIT_WIDTH-1:0] in_data,
    output logic                 out_valid,
    output logic                 out_sof,
    output logic                 out_diff,
    output logic [BIT_WIDTH-1:0] out_data,
    output logic                 sync_err
);

    localparam int W  = half_w(BIT_WIDTH);
    localparam int CW = $clog2(2 * DELAY_STAGES);
    localparam logic [CW-1:0] CNT_LAST = CW'(2 * DELAY_STAGES - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(DELAY_STAGES);
    localparam logic [CW-1:0] CNT_HM1  = CW'(DELAY_STAGES - 1);

    // Reduce a half-width+1 sum/difference back to W bits.
    function automatic logic signed [W-1:0] shape(input logic signed [W:0] v);
        logic signed [63:0] c;
        c = sat_clamp(64'(v), W);
        if (SCALE != 0) begin
            shape = v[W:1];
        end else begin
            shape = c[W-1:0];
        end
    endfunction

    logic [CW-1:0]        cnt, cnt_eff, cnt_nxt;
    bfu_state_t           state, state_eff, state_nxt;
    logic                 resync;
    logic [BIT_WIDTH-1:0] dly_out, dly_in, sum_w, diff_w;
    logic signed [W-1:0]  a_re, a_im, b_re, b_im;
    logic signed [W:0]    s_re, s_im, d_re, d_im;

    logic                 vld_p1, sof_p1, diff_p1, sync_err_p1;
    logic [BIT_WIDTH-1:0] data_p1;

    assign a_re = dly_out[BIT_WIDTH-1:W];
    assign a_im = dly_out[W-1:0];
    assign b_re = in_data[BIT_WIDTH-1:W];
    assign b_im = in_data[W-1:0];

    assign s_re = {a_re[W-1], a_re} + {b_re[W-1], b_re};
    assign s_im = {a_im[W-1], a_im} + {b_im[W-1], b_im};
    assign d_re = {a_re[W-1], a_re} - {b_re[W-1], b_re};
    assign d_im = {a_im[W-1], a_im} - {b_im[W-1], b_im};

    assign sum_w  = {shape(s_re), shape(s_im)};
    assign diff_w = {shape(d_re), shape(d_im)};

    // A misaligned start of frame restarts the frame at this sample.
    always_comb begin
        resync    = in_valid && in_sof && (cnt != '0);
        cnt_eff   = resync ? '0 : cnt;
        state_eff = resync ? FILL : state;
        cnt_nxt   = (cnt_eff == CNT_LAST) ? '0 : cnt_eff + CW'(1);
        state_nxt = state_eff;
        case (state_eff)
            FILL, DRAIN: if (cnt_eff == CNT_HM1) state_nxt = BFLY;
            BFLY:        if (cnt_eff == CNT_LAST) state_nxt = DRAIN;
            default:     state_nxt = FILL;
        endcase
        dly_in = (state_eff == BFLY) ? diff_w : in_data;
    end

    fb_delay_line #(
        .BIT_WIDTH (BIT_WIDTH),
        .DEPTH     (DELAY_STAGES)
    ) u_fb_delay_line (
        .clk  (clk),
        .clr  (reset),
        .en   (in_valid),
        .din  (dly_in),
        .dout (dly_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            state       <= FILL;
            sync_err_p1 <= 1'b0;
        end else begin
            sync_err_p1 <= resync;
            if (in_valid) begin
                cnt   <= cnt_nxt;
                state <= state_nxt;
            end
        end
    end

    // p0 -> p1: register the output word of the accepted sample
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            sof_p1  <= 1'b0;
            diff_p1 <= 1'b0;
            data_p1 <= '0;
        end else begin
            vld_p1 <= in_valid && (state_eff != FILL);
            if (in_valid && state_eff == BFLY) begin
                data_p1 <= sum_w;
                sof_p1  <= (cnt_eff == CNT_HALF);
                diff_p1 <= 1'b0;
            end else if (in_valid && state_eff == DRAIN) begin
                data_p1 <= dly_out;
                sof_p1  <= 1'b0;
                diff_p1 <= 1'b1;
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_sof   = sof_p1;
    assign out_diff  = diff_p1;
    assign out_data  = data_p1;
    assign sync_err  = sync_err_p1;

endmodule
